// File: rtl/i2c_target_shift_if.sv
// User-side handshake bundle of the I2C target byte engine.
// The slave modport is the engine's view; the master modport is the user
// logic's view (register-bank front end or bench).
interface i2c_target_shift_if;
  logic [7:0] Tx_DATA;
  logic       Tx_Req;
  logic [7:0] Rx_DATA;
  logic       Rx_Valid;
  logic       Addr_Match;
  logic       Rd_Wr;
  logic       Stop_Det;
  logic       Busy;

  modport slave (
    input  Tx_DATA,
    output Tx_Req, Rx_DATA, Rx_Valid, Addr_Match, Rd_Wr, Stop_Det, Busy
  );

  modport master (
    output Tx_DATA,
    input  Tx_Req, Rx_DATA, Rx_Valid, Addr_Match, Rd_Wr, Stop_Det, Busy
  );
endinterface

// File: rtl/i2c_target_shift.sv
// I2C target byte engine: oversampled SCL/SDA, START/STOP detection,
// 7-bit address match with ACK, byte receive and byte transmit.
// Optional macro I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority
// filter on SCL and SDA after the synchronizer (+2 Clk edge latency).
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | released, waiting for START
// ADDR      | shifting in the address byte
// ADDR_ACK  | driving ACK for our own address
// WR_BYTE   | receiving a data byte from the master
// WR_ACK    | driving ACK for a received byte
// RD_BYTE   | shifting a data byte out to the master
// RD_ACK    | SDA released, sampling the master's ACK/NACK
// WAIT_STOP | master NACKed, stay released and busy until STOP/START
module i2c_target_shift #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                i2c_sclk,
  inout  wire                 i2c_sdat,
  i2c_target_shift_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic w_scl_q, w_sda_q;
  logic r_scl_qq, r_sda_qq;

  // Synchronizers reset to the idle-high bus level so reset release makes no false edges.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i2c_sclk};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i2c_sdat};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] r_scl_win, r_sda_win;
  logic       r_scl_flt, r_sda_flt;

  // Majority of the last three samples; a 1-Clk pulse never wins the vote.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_scl_win <= 3'b111;
      r_sda_win <= 3'b111;
      r_scl_flt <= 1'b1;
      r_sda_flt <= 1'b1;
    end else begin
      r_scl_win <= {r_scl_win[1:0], r_scl_sync[SYNC_STAGES-1]};
      r_sda_win <= {r_sda_win[1:0], r_sda_sync[SYNC_STAGES-1]};
      r_scl_flt <= (r_scl_win[0] & r_scl_win[1]) | (r_scl_win[0] & r_scl_win[2]) |
                   (r_scl_win[1] & r_scl_win[2]);
      r_sda_flt <= (r_sda_win[0] & r_sda_win[1]) | (r_sda_win[0] & r_sda_win[2]) |
                   (r_sda_win[1] & r_sda_win[2]);
    end
  end

  assign w_scl_q = r_scl_flt;
  assign w_sda_q = r_sda_flt;
`else
  assign w_scl_q = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_q = r_sda_sync[SYNC_STAGES-1];
`endif

  // One extra flop per line gives the previous sample for edge detection.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_scl_qq <= 1'b1;
      r_sda_qq <= 1'b1;
    end else begin
      r_scl_qq <= w_scl_q;
      r_sda_qq <= w_sda_q;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl_q & ~r_scl_qq;
  assign w_scl_fall = ~w_scl_q & r_scl_qq;
  assign w_start    = ~w_sda_q & r_sda_qq & w_scl_q & r_scl_qq;
  assign w_stop     = w_sda_q & ~r_sda_qq & w_scl_q & r_scl_qq;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_full, w_full_nxt;
  logic       r_sda_low, w_sda_low_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_addr_match, w_addr_match_nxt;
  logic       r_rd_wr, w_rd_wr_nxt;
  logic       r_stop_det, w_stop_det_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_tx_req, w_tx_req_nxt;
  logic [1:0] r_ld_cnt, w_ld_cnt_nxt;
  logic       r_mack, w_mack_nxt;

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_full       <= 1'b0;
      r_sda_low    <= 1'b0;
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_addr_match <= 1'b0;
      r_rd_wr      <= 1'b0;
      r_stop_det   <= 1'b0;
      r_busy       <= 1'b0;
      r_tx_req     <= 1'b0;
      r_ld_cnt     <= 2'd0;
      r_mack       <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_full       <= w_full_nxt;
      r_sda_low    <= w_sda_low_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_addr_match <= w_addr_match_nxt;
      r_rd_wr      <= w_rd_wr_nxt;
      r_stop_det   <= w_stop_det_nxt;
      r_busy       <= w_busy_nxt;
      r_tx_req     <= w_tx_req_nxt;
      r_ld_cnt     <= w_ld_cnt_nxt;
      r_mack       <= w_mack_nxt;
    end
  end

  // Next-state and output logic; START/STOP override any SCL edge handling.
  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_full_nxt       = r_full;
    w_sda_low_nxt    = r_sda_low;
    w_rx_data_nxt    = r_rx_data;
    w_rx_valid_nxt   = 1'b0;
    w_addr_match_nxt = 1'b0;
    w_rd_wr_nxt      = r_rd_wr;
    w_stop_det_nxt   = 1'b0;
    w_busy_nxt       = r_busy;
    w_tx_req_nxt     = 1'b0;
    w_ld_cnt_nxt     = (r_ld_cnt != 2'd0) ? r_ld_cnt - 2'd1 : 2'd0;
    w_mack_nxt       = r_mack;

    // Tx_DATA is taken two Clk after Tx_Req; its MSB goes straight onto the bus.
    if (r_ld_cnt == 2'd1) begin
      w_shift_nxt   = bus.Tx_DATA;
      w_sda_low_nxt = ~bus.Tx_DATA[7];
      w_bit_cnt_nxt = 3'd0;
    end

    if (w_stop) begin
      w_state_nxt    = IDLE;
      w_sda_low_nxt  = 1'b0;
      w_busy_nxt     = 1'b0;
      w_stop_det_nxt = 1'b1;
      w_bit_cnt_nxt  = 3'd0;
      w_full_nxt     = 1'b0;
      w_ld_cnt_nxt   = 2'd0;
    end else if (w_start) begin
      w_state_nxt   = ADDR;
      w_sda_low_nxt = 1'b0;
      w_bit_cnt_nxt = 3'd0;
      w_full_nxt    = 1'b0;
      w_ld_cnt_nxt  = 2'd0;
    end else begin
      case (r_state)
        IDLE: ;
        ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt   = {r_shift[6:0], w_sda_q};
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_full_nxt    = (r_bit_cnt == 3'd7);
          end else if (w_scl_fall && r_full) begin
            w_full_nxt = 1'b0;
            if (r_shift[7:1] == SLAVE_ADDR) begin
              w_sda_low_nxt    = 1'b1;
              w_state_nxt      = ADDR_ACK;
              w_busy_nxt       = 1'b1;
              w_rd_wr_nxt      = r_shift[0];
              w_addr_match_nxt = 1'b1;
            end else begin
              w_sda_low_nxt = 1'b0;
              w_state_nxt   = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (w_scl_fall) begin
            w_sda_low_nxt = 1'b0;
            w_bit_cnt_nxt = 3'd0;
            if (r_rd_wr) begin
              w_tx_req_nxt = 1'b1;
              w_ld_cnt_nxt = 2'd2;
              w_state_nxt  = RD_BYTE;
            end else begin
              w_state_nxt = WR_BYTE;
            end
          end
        end
        WR_BYTE: begin
          if (w_scl_rise) begin
            w_shift_nxt   = {r_shift[6:0], w_sda_q};
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_rx_data_nxt  = {r_shift[6:0], w_sda_q};
              w_rx_valid_nxt = 1'b1;
              w_full_nxt     = 1'b1;
            end
          end else if (w_scl_fall && r_full) begin
            w_full_nxt    = 1'b0;
            w_sda_low_nxt = 1'b1;
            w_state_nxt   = WR_ACK;
          end
        end
        WR_ACK: begin
          if (w_scl_fall) begin
            w_sda_low_nxt = 1'b0;
            w_bit_cnt_nxt = 3'd0;
            w_state_nxt   = WR_BYTE;
          end
        end
        RD_BYTE: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 3'd7) begin
              w_sda_low_nxt = 1'b0;
              w_bit_cnt_nxt = 3'd0;
              w_state_nxt   = RD_ACK;
            end else begin
              w_shift_nxt   = {r_shift[6:0], 1'b0};
              w_sda_low_nxt = ~r_shift[6];
              w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (w_scl_rise) begin
            w_mack_nxt = w_sda_q;
          end else if (w_scl_fall) begin
            if (!r_mack) begin
              w_tx_req_nxt = 1'b1;
              w_ld_cnt_nxt = 2'd2;
              w_state_nxt  = RD_BYTE;
            end else begin
              w_state_nxt = WAIT_STOP;
            end
          end
        end
        WAIT_STOP: ;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign i2c_sdat       = r_sda_low ? 1'b0 : 1'bz;
  assign bus.Tx_Req     = r_tx_req;
  assign bus.Rx_DATA    = r_rx_data;
  assign bus.Rx_Valid   = r_rx_valid;
  assign bus.Addr_Match = r_addr_match;
  assign bus.Rd_Wr      = r_rd_wr;
  assign bus.Stop_Det   = r_stop_det;
  assign bus.Busy       = r_busy;

endmodule

// File: tb/tb_i2c_target_shift.sv
// Directed bench for i2c_target_shift: a behavioural I2C master drives the
// bus, a negedge monitor counts the user-side pulses.
module tb_i2c_target_shift;
  localparam int Q = 20;

  logic Clk = 1'b0;
  logic Rst_n;
  logic scl;
  logic m_sda_low;
  wire  sda;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_target_shift_if u_bus ();

  i2c_target_shift #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) u_dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .i2c_sclk (scl),
    .i2c_sdat (sda),
    .bus      (u_bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_am = 0, cnt_rx = 0, cnt_stop = 0, cnt_txreq = 0;
  logic [7:0] rx_log [4];
  logic last_rdwr = 1'b0;
  logic coincide = 1'b0;

  always @(negedge Clk) begin
    if (u_bus.Addr_Match) begin
      cnt_am++;
      last_rdwr = u_bus.Rd_Wr;
    end
    if (u_bus.Rx_Valid) begin
      if (cnt_rx < 4) rx_log[cnt_rx] = u_bus.Rx_DATA;
      cnt_rx++;
    end
    if (u_bus.Stop_Det) cnt_stop++;
    if (u_bus.Tx_Req) cnt_txreq++;
    if (u_bus.Stop_Det && u_bus.Addr_Match) coincide = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic clear_counts();
    cnt_am = 0; cnt_rx = 0; cnt_stop = 0; cnt_txreq = 0;
  endtask

  task automatic m_start();
    m_sda_low = 1'b0; waitc(Q);
    scl = 1'b1;       waitc(Q);
    m_sda_low = 1'b1; waitc(Q);
    scl = 1'b0;       waitc(Q);
  endtask

  task automatic m_stop();
    m_sda_low = 1'b1; waitc(Q);
    scl = 1'b1;       waitc(Q);
    m_sda_low = 1'b0; waitc(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; waitc(Q);
    scl = 1'b1;     waitc(2 * Q);
    scl = 1'b0;     waitc(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; waitc(Q);
    scl = 1'b1;       waitc(Q);
    b = sda;          waitc(Q);
    scl = 1'b0;       waitc(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_bits8(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  logic       ack;
  logic [7:0] rd;

  initial begin
    Rst_n = 1'b0; scl = 1'b1; m_sda_low = 1'b0; u_bus.Tx_DATA = 8'h00;
    waitc(5);
    check("rst_busy", u_bus.Busy, 0);
    check("rst_rxdata", u_bus.Rx_DATA, 8'h00);
    check("rst_pulses", {u_bus.Rx_Valid, u_bus.Addr_Match, u_bus.Stop_Det, u_bus.Tx_Req, u_bus.Rd_Wr}, 0);
    check("rst_sda", sda, 1);
    Rst_n = 1'b1;
    waitc(5);

    // write 0x50/W, 0xA5, 0x3C, STOP
    clear_counts();
    m_start();
    write_byte(8'hA0, ack);
    check("wr_addr_ack", ack, 0);
    check("wr_busy", u_bus.Busy, 1);
    write_byte(8'hA5, ack);
    check("wr_ack1", ack, 0);
    write_byte(8'h3C, ack);
    check("wr_ack2", ack, 0);
    m_stop();
    waitc(10);
    check("wr_addr_match_cnt", cnt_am, 1);
    check("wr_rdwr", last_rdwr, 0);
    check("wr_rx_cnt", cnt_rx, 2);
    check("wr_rx0", rx_log[0], 8'hA5);
    check("wr_rx1", rx_log[1], 8'h3C);
    check("wr_rxdata_held", u_bus.Rx_DATA, 8'h3C);
    check("wr_stop_cnt", cnt_stop, 1);
    check("wr_busy_after_stop", u_bus.Busy, 0);

    // read 0x50/R, 0x81 (ACK), 0x7E (NACK)
    clear_counts();
    u_bus.Tx_DATA = 8'h81;
    m_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", ack, 0);
    read_bits8(rd);
    check("rd_byte0", rd, 8'h81);
    u_bus.Tx_DATA = 8'h7E;
    write_bit(1'b0);
    read_bits8(rd);
    check("rd_byte1", rd, 8'h7E);
    write_bit(1'b1);
    waitc(10);
    check("rd_sda_released", sda, 1);
    check("rd_busy_wait_stop", u_bus.Busy, 1);
    check("rd_txreq_cnt", cnt_txreq, 2);
    check("rd_rdwr", last_rdwr, 1);
    m_stop();
    waitc(10);
    check("rd_busy_after_stop", u_bus.Busy, 0);

    // address 0x51/W: no ACK
    clear_counts();
    m_start();
    write_byte(8'hA2, ack);
    check("nm_nack", ack, 1);
    check("nm_busy", u_bus.Busy, 0);
    m_stop();
    waitc(10);
    check("nm_addr_match_cnt", cnt_am, 0);
    check("nm_rx_cnt", cnt_rx, 0);
    check("nm_stop_cnt", cnt_stop, 1);

    // write 0x50/W, 0x12, repeated START, 0x50/R
    clear_counts();
    u_bus.Tx_DATA = 8'hC3;
    m_start();
    write_byte(8'hA0, ack);
    write_byte(8'h12, ack);
    check("rs_ack_data", ack, 0);
    check("rs_rxdata", u_bus.Rx_DATA, 8'h12);
    m_start();
    check("rs_busy_after_rstart", u_bus.Busy, 1);
    write_byte(8'hA1, ack);
    check("rs_addr_ack", ack, 0);
    check("rs_addr_match_cnt", cnt_am, 2);
    check("rs_rdwr", last_rdwr, 1);
    check("rs_busy", u_bus.Busy, 1);
    read_bits8(rd);
    check("rs_rd_byte", rd, 8'hC3);
    write_bit(1'b1);
    m_stop();
    waitc(10);
    check("rs_stop_cnt", cnt_stop, 1);

    // 1-Clk SCL glitch during data bit 4 of 0x5A
    clear_counts();
    m_start();
    write_byte(8'hA0, ack);
    begin
      logic [7:0] d;
      d = 8'h5A;
      for (int i = 7; i >= 0; i--) begin
        m_sda_low = ~d[i];
        waitc(Q / 2);
        if (i == 4) begin
          scl = 1'b1; waitc(1);
          scl = 1'b0;
        end
        waitc(Q / 2);
        scl = 1'b1; waitc(2 * Q);
        scl = 1'b0; waitc(Q);
      end
    end
    read_bit(ack);
    m_stop();
    waitc(10);
    check("gl_rx_cnt", cnt_rx, 1);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    check("gl_rxdata", u_bus.Rx_DATA, 8'h5A);
    check("gl_ack", ack, 0);
`else
    check("gl_rxdata", u_bus.Rx_DATA, 8'h5D);
    check("gl_ack", ack, 1);
`endif

    // reset during bit 4 of a read of 0x00
    clear_counts();
    u_bus.Tx_DATA = 8'h00;
    m_start();
    write_byte(8'hA1, ack);
    check("mr_addr_ack", ack, 0);
    for (int i = 0; i < 3; i++) read_bit(ack);
    check("mr_sda_driven", sda, 0);
    Rst_n = 1'b0;
    #1;
    check("mr_sda_released", sda, 1);
    waitc(2);
    check("mr_busy", u_bus.Busy, 0);
    check("mr_rdwr", u_bus.Rd_Wr, 0);
    check("mr_rxdata", u_bus.Rx_DATA, 8'h00);
    Rst_n = 1'b1;
    waitc(5);
    clear_counts();
    m_start();
    write_byte(8'hA0, ack);
    check("mr_re_addr_ack", ack, 0);
    write_byte(8'h5A, ack);
    check("mr_re_ack", ack, 0);
    m_stop();
    waitc(10);
    check("mr_re_rxdata", u_bus.Rx_DATA, 8'h5A);
    check("mr_re_stop_cnt", cnt_stop, 1);

    check("stop_and_match_coincide", coincide, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
